// File: rtl/ext_mem_arbiter_if.sv
// rtl/ext_mem_arbiter_if.sv - request/stall/external-bus bundle between pipeline and ext_mem_arbiter
// ext_rdy exists only when ARB_EXT_READY_EN is defined.
interface ext_mem_arbiter_if;
  logic        pm_req;
  logic [15:0] pm_add;
  logic        dm_req;
  logic [15:0] dm_add;
  logic        rwb;
`ifdef ARB_EXT_READY_EN
  logic        ext_rdy;
`endif
  logic [15:0] ext_add;
  logic        ext_rwb;
  logic        ext_cs;
  logic        ext_sel;
  logic        pm_stall;
  logic        dm_stall;
  logic        pm_done;
  logic        dm_done;

  modport slave (
    input  pm_req, pm_add, dm_req, dm_add, rwb,
    output ext_add, ext_rwb, ext_cs, ext_sel, pm_stall, dm_stall, pm_done, dm_done
`ifdef ARB_EXT_READY_EN
    , input ext_rdy
`endif
  );

  modport master (
    output pm_req, pm_add, dm_req, dm_add, rwb,
    input  ext_add, ext_rwb, ext_cs, ext_sel, pm_stall, dm_stall, pm_done, dm_done
`ifdef ARB_EXT_READY_EN
    , output ext_rdy
`endif
  );
endinterface

// File: rtl/ext_mem_arbiter.sv
// rtl/ext_mem_arbiter.sv - one-at-a-time external memory access for PM fetch and DM, fixed wait states
// Define ARB_EXT_READY_EN to also wait for the device's ext_rdy before completing.
module ext_mem_arbiter #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  ext_mem_arbiter_if.slave bus
);
  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_e;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] add_q, add_d;
  logic        rwb_q, rwb_d;
  logic        sel_q, sel_d;
  logic        pm_ext, dm_ext, rdy, finish;
  logic        pm_done, dm_done;

  assign pm_ext = bus.pm_req & (|bus.pm_add[15:12]);
  assign dm_ext = bus.dm_req & (|bus.dm_add[15:12]);

`ifdef ARB_EXT_READY_EN
  assign rdy = bus.ext_rdy;
`else
  assign rdy = 1'b1;
`endif

  assign finish = (state_q == ACCESS) & (cnt_q == 4'd0) & rdy;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      add_q   <= 16'h0000;
      rwb_q   <= 1'b1;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      add_q   <= add_d;
      rwb_q   <= rwb_d;
      sel_q   <= sel_d;
    end
  end

  // DM wins ties: it belongs to the older instruction in the pipe.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    add_d   = add_q;
    rwb_d   = rwb_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE: begin
        if (dm_ext) begin
          sel_d   = 1'b1;
          add_d   = bus.dm_add;
          rwb_d   = bus.rwb;
          cnt_d   = WAIT_INIT;
          state_d = ACCESS;
        end else if (pm_ext) begin
          sel_d   = 1'b0;
          add_d   = bus.pm_add;
          rwb_d   = 1'b1;
          cnt_d   = WAIT_INIT;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (finish) begin
          state_d = IDLE;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Owner withdrawal is ignored once granted; only reset aborts a bus cycle.
  always_comb begin
    pm_done      = ~rst_i & finish & ~sel_q;
    dm_done      = ~rst_i & finish & sel_q;
    bus.pm_done  = pm_done;
    bus.dm_done  = dm_done;
    bus.pm_stall = ~rst_i & pm_ext & ~pm_done;
    bus.dm_stall = ~rst_i & dm_ext & ~dm_done;
    bus.ext_cs   = (state_q == ACCESS);
    bus.ext_add  = add_q;
    bus.ext_rwb  = rwb_q;
    bus.ext_sel  = sel_q;
  end
endmodule

// File: tb/tb_ext_mem_arbiter.sv
// tb/tb_ext_mem_arbiter.sv - directed bench for ext_mem_arbiter, WAIT_CYCLES=0 and 2 side by side
module tb_ext_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        pm_req, dm_req, rwb, rdy;
  logic [15:0] pm_add, dm_add;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  ext_mem_arbiter_if bus0();
  ext_mem_arbiter_if bus2();

  assign bus0.pm_req = pm_req;
  assign bus0.pm_add = pm_add;
  assign bus0.dm_req = dm_req;
  assign bus0.dm_add = dm_add;
  assign bus0.rwb    = rwb;
  assign bus2.pm_req = pm_req;
  assign bus2.pm_add = pm_add;
  assign bus2.dm_req = dm_req;
  assign bus2.dm_add = dm_add;
  assign bus2.rwb    = rwb;
`ifdef ARB_EXT_READY_EN
  assign bus0.ext_rdy = rdy;
  assign bus2.ext_rdy = rdy;
`endif

  ext_mem_arbiter #(.WAIT_CYCLES(0)) u_w0 (.clk_i(clk), .rst_i(rst), .bus(bus0));
  ext_mem_arbiter #(.WAIT_CYCLES(2)) u_w2 (.clk_i(clk), .rst_i(rst), .bus(bus2));

  logic [22:0] o0, o2;
  assign o0 = {bus0.ext_add, bus0.ext_rwb, bus0.ext_cs, bus0.ext_sel,
               bus0.pm_stall, bus0.dm_stall, bus0.pm_done, bus0.dm_done};
  assign o2 = {bus2.ext_add, bus2.ext_rwb, bus2.ext_cs, bus2.ext_sel,
               bus2.pm_stall, bus2.dm_stall, bus2.pm_done, bus2.dm_done};

  // Model: an access granted at cycle t may finish at cycle t+W+1 or later (when rdy).
  bit          m_valid = 1'b0;
  int          t = 0;
  bit          m_busy [2];
  bit          m_sel  [2];
  bit          m_rwb  [2];
  logic [15:0] m_add  [2];
  int          m_due  [2];

  function automatic int wait_of(int i);
    return (i == 0) ? 0 : 2;
  endfunction

  function automatic logic [22:0] expect_vec(int i);
    bit pm_ext, dm_ext, fin, pmd, dmd;
    pm_ext = pm_req && (pm_add[15:12] != 4'd0);
    dm_ext = dm_req && (dm_add[15:12] != 4'd0);
    fin    = !rst && m_busy[i] && (t >= m_due[i]) && rdy;
    pmd    = fin && !m_sel[i];
    dmd    = fin && m_sel[i];
    return {m_add[i], m_rwb[i], m_busy[i], m_sel[i],
            !rst && pm_ext && !pmd, !rst && dm_ext && !dmd, pmd, dmd};
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_busy[i] <= 1'b0;
        m_sel[i]  <= 1'b0;
        m_rwb[i]  <= 1'b1;
        m_add[i]  <= 16'h0000;
      end else if (m_busy[i]) begin
        if (t >= m_due[i] && rdy) m_busy[i] <= 1'b0;
      end else if (dm_req && dm_add[15:12] != 4'd0) begin
        m_busy[i] <= 1'b1;
        m_sel[i]  <= 1'b1;
        m_rwb[i]  <= rwb;
        m_add[i]  <= dm_add;
        m_due[i]  <= t + wait_of(i) + 1;
      end else if (pm_req && pm_add[15:12] != 4'd0) begin
        m_busy[i] <= 1'b1;
        m_sel[i]  <= 1'b0;
        m_rwb[i]  <= 1'b1;
        m_add[i]  <= pm_add;
        m_due[i]  <= t + wait_of(i) + 1;
      end
    end
    t       <= t + 1;
    m_valid <= 1'b1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      for (int i = 0; i < 2; i++) begin
        logic [22:0] ev, av;
        ev = expect_vec(i);
        av = (i == 0) ? o0 : o2;
        n_tests++;
        if (av !== ev) begin
          n_fail++;
          $display("FAIL model_w%0d cycle %0d: got %h expected %h", wait_of(i), t, av, ev);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    pm_req = 1'b0;
    dm_req = 1'b0;
    rwb    = 1'b1;
    repeat (n) next_cycle();
  endtask

  initial begin
    rst = 1'b1; pm_req = 1'b1; pm_add = 16'h1FFF;
    dm_req = 1'b0; dm_add = 16'h0000; rwb = 1'b1; rdy = 1'b1;
    @(negedge clk);
    chk("rst_pm_stall_first", bus2.pm_stall, 1'b0);
    next_cycle();
    @(negedge clk);
    chk("rst_ext_cs", bus2.ext_cs, 1'b0);
    chk("rst_ext_add", bus2.ext_add, 16'h0000);
    chk("rst_ext_rwb", bus2.ext_rwb, 1'b1);
    chk("rst_ext_sel", bus2.ext_sel, 1'b0);
    chk("rst_pm_stall", bus2.pm_stall, 1'b0);
    next_cycle();
    rst = 1'b0; pm_add = 16'h01FF; dm_req = 1'b1; dm_add = 16'h0FFF;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("int_ext_cs", bus2.ext_cs, 1'b0);
      chk("int_stalls", {bus2.pm_stall, bus2.dm_stall}, 2'b00);
      next_cycle();
    end
    idle(3);

    pm_req = 1'b1; pm_add = 16'h1FFF;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      case (c)
        0: begin chk("pm1_stall_c0", bus2.pm_stall, 1'b1); chk("pm1_cs_c0", bus2.ext_cs, 1'b0); end
        1: begin chk("pm1_cs_c1", bus2.ext_cs, 1'b1); chk("pm1_add_c1", bus2.ext_add, 16'h1FFF); end
        2: begin chk("pm1_stall_c2", bus2.pm_stall, 1'b1); chk("pm1_rwb_c2", bus2.ext_rwb, 1'b1); end
        default: begin chk("pm1_done_c3", bus2.pm_done, 1'b1); chk("pm1_stall_c3", bus2.pm_stall, 1'b0); end
      endcase
      next_cycle();
    end
    idle(6);

    pm_req = 1'b1; pm_add = 16'h1FFF; dm_req = 1'b1; dm_add = 16'h1AFF; rwb = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      case (c)
        0: begin chk("sim_dm_stall_c0", bus2.dm_stall, 1'b1); chk("sim_pm_stall_c0", bus2.pm_stall, 1'b1); end
        3: begin chk("sim_dm_done_c3", bus2.dm_done, 1'b1); chk("sim_rwb_c3", bus2.ext_rwb, 1'b0);
                 chk("sim_sel_c3", bus2.ext_sel, 1'b1); end
        4: begin chk("sim_cs_c4", bus2.ext_cs, 1'b0); chk("sim_pm_stall_c4", bus2.pm_stall, 1'b1); end
        5: begin chk("sim_add_c5", bus2.ext_add, 16'h1FFF); chk("sim_sel_c5", bus2.ext_sel, 1'b0); end
        6: chk("sim_pm_stall_c6", bus2.pm_stall, 1'b1);
        7: begin chk("sim_pm_done_c7", bus2.pm_done, 1'b1); chk("sim_pm_stall_c7", bus2.pm_stall, 1'b0); end
        default: ;
      endcase
      next_cycle();
      if (c == 3) begin dm_req = 1'b0; rwb = 1'b1; end
      if (c == 7) pm_req = 1'b0;
    end
    idle(6);

    dm_req = 1'b1; dm_add = 16'h3000; rwb = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 3) begin
        chk("wd_dm_done_c3", bus2.dm_done, 1'b1);
        chk("wd_cs_c3", bus2.ext_cs, 1'b1);
      end
      next_cycle();
      if (c == 0) dm_req = 1'b0;
    end
    idle(6);

    pm_req = 1'b1; pm_add = 16'h4000;
    next_cycle();
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_done_c2", bus2.pm_done, 1'b0);
    chk("rst_mid_stall_c2", bus2.pm_stall, 1'b0);
    next_cycle();
    rst = 1'b0; pm_req = 1'b0;
    @(negedge clk);
    chk("rst_mid_cs_c3", bus2.ext_cs, 1'b0);
    chk("rst_mid_done_c3", bus2.pm_done, 1'b0);
    idle(6);

    pm_req = 1'b1; pm_add = 16'h2000;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      case (c)
        1: begin chk("b2b_done_c1", bus0.pm_done, 1'b1); chk("b2b_add_c1", bus0.ext_add, 16'h2000); end
        2: begin chk("b2b_cs_c2", bus0.ext_cs, 1'b0); chk("b2b_stall_c2", bus0.pm_stall, 1'b1); end
        3: begin chk("b2b_done_c3", bus0.pm_done, 1'b1); chk("b2b_add_c3", bus0.ext_add, 16'h2002); end
        default: ;
      endcase
      next_cycle();
      if (c == 1) pm_add = 16'h2002;
    end
    idle(6);

`ifdef ARB_EXT_READY_EN
    pm_req = 1'b1; pm_add = 16'h5000; rdy = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 4) begin
        chk("rdy_stall_c4", bus2.pm_stall, 1'b1);
        chk("rdy_cs_c4", bus2.ext_cs, 1'b1);
      end
      if (c == 5) chk("rdy_done_c5", bus2.pm_done, 1'b1);
      next_cycle();
      if (c == 4) rdy = 1'b1;
      if (c == 5) pm_req = 1'b0;
    end
    idle(6);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ext_mem_arbiter.md
# ext_mem_arbiter

Shares the single slow external memory port between the program-memory fetch requester and the data-memory requester of the RISC pipeline. An access is external when bits [15:12] of its address are non-zero. The block grants one external access at a time, inserts a fixed number of wait states, and drives per-requester stall signals. The pipeline stall/clock-enable logic consumes these stalls in place of raw address decode. Internal accesses (address[15:12] == 0) bypass the block entirely and never stall.

## Interface
Parameters:
- WAIT_CYCLES, 2, wait states per external access; legal range 0..15; 4-bit counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- pm_req  in  1  fetch valid this cycle.
- pm_add  in  16  fetch address.
- dm_req  in  1  data access valid this cycle.
- dm_add  in  16  data address.
- rwb  in  1  data direction: 1 = read, 0 = write. PM accesses are always reads.
- ext_rdy  in  1  external device ready. Present only with ARB_EXT_READY_EN.
- ext_add  out  16  registered external address.
- ext_rwb  out  1  registered external direction.
- ext_cs  out  1  registered external chip select.
- ext_sel  out  1  owner of the current access: 0 = PM, 1 = DM.
- pm_stall  out  1  combinational; hold fetch stage.
- dm_stall  out  1  combinational; hold data-access stage.
- pm_done  out  1  one-cycle pulse: PM external access completes this cycle.
- dm_done  out  1  one-cycle pulse: DM external access completes this cycle.

## Operation
- Decode:
  - pm_ext = pm_req & |pm_add[15:12]
  - dm_ext = dm_req & |dm_add[15:12]
- States:
  - IDLE: ext_cs = 0.
  - ACCESS: ext_cs = 1; cnt counts down.
- IDLE behaviour:
  - If dm_ext, grant DM: ext_sel<=1, ext_add<=dm_add, ext_rwb<=rwb.
  - Else if pm_ext, grant PM: ext_sel<=0, ext_add<=pm_add, ext_rwb<=1.
  - On a grant: cnt<=WAIT_CYCLES, state<=ACCESS.
  - DM has fixed priority over PM, since DM belongs to the older instruction.
- ACCESS behaviour:
  - Completion condition: cnt==0 (with the macro: cnt==0 & ext_rdy).
  - On completion: pulse the owner's done, state<=IDLE.
  - Otherwise, if cnt != 0: cnt<=cnt-1.
- ext_add, ext_rwb and ext_sel hold stable for the whole ACCESS state. ext_add and ext_sel keep their last value in IDLE.
- Stall equations:
  - pm_stall = pm_ext & ~pm_done
  - dm_stall = dm_ext & ~dm_done
  - Both are forced to 0 while rst is high.
- A non-granted requester with a pending external request stays stalled until it is granted and completes.
- The owner withdrawing its request during ACCESS does not abort the bus cycle. The access runs to completion and done still pulses.
- Every access returns to IDLE for at least one cycle before the next grant, including back-to-back accesses from the same requester.

## Timing
- Reset values: state IDLE, cnt 0, ext_cs 0, ext_add 16'h0000, ext_rwb 1, ext_sel 0, pm_done 0, dm_done 0.
- Request first seen in IDLE at cycle 0:
  - ext_cs is high from cycle 1.
  - Completion and done pulse at cycle WAIT_CYCLES+1.
  - Stall is high in cycles 0..WAIT_CYCLES and low in cycle WAIT_CYCLES+1.
- WAIT_CYCLES=0: a single ACCESS cycle; done at cycle 1.
- Simultaneous pm_ext and dm_ext in IDLE:
  - DM access completes at cycle W+1; the block is IDLE at cycle W+2.
  - PM is granted at cycle W+2 and completes at cycle 2W+3.
- rst asserted mid-ACCESS: IDLE and all reset values at the next edge, with no done pulse. The requester re-requests after reset.
- A new request arriving during another owner's ACCESS is stalled immediately (combinational stall) and is not latched until IDLE.

## Configuration
- ARB_EXT_READY_EN defined:
  - ext_rdy port exists.
  - ACCESS completes only when cnt==0 and ext_rdy==1; cnt holds at 0 while ext_rdy==0.
  - Stall extends accordingly.
- ARB_EXT_READY_EN undefined:
  - No ext_rdy port.
  - Completion is purely on the wait-state counter (fixed latency).

## Test plan
- Reset and internal traffic:
  - Stimulus: rst held 2 cycles with pm_req=1, pm_add=16'h1FFF; then rst=0, pm_add=16'h01FF, dm_add=16'h0FFF.
  - Required: stalls 0 during reset; all outputs at reset values; ext_cs never asserts; no stall.
- Single PM external fetch:
  - Stimulus: WAIT_CYCLES=2, pm_add=16'h1FFF held.
  - Required: pm_stall high 3 cycles; ext_cs high cycles 1..3 with ext_add=16'h1FFF and ext_rwb=1; pm_done at cycle 3.
- Simultaneous requests:
  - Stimulus: pm_add=16'h1FFF and dm_add=16'h1AFF with rwb=0, both in the same cycle.
  - Required: DM served first (ext_rwb=0, dm_done at cycle 3); PM granted at cycle 4, pm_done at cycle 7; pm_stall high cycles 0..6.
- Withdrawal and reset mid-access:
  - Stimulus: dm_req drops at cycle 1 of a DM access.
  - Required: access completes and dm_done pulses at cycle 3.
  - Stimulus: a separate access with rst asserted at cycle 2.
  - Required: IDLE next cycle, ext_cs=0, no done pulse.
- WAIT_CYCLES=0 back-to-back:
  - Stimulus: PM fetches at 16'h2000 then 16'h2002.
  - Required: pm_done at cycles 1 and 3, with an IDLE cycle at cycle 2.
- ARB_EXT_READY_EN build:
  - Stimulus: ext_rdy low until cycle 5, WAIT_CYCLES=2.
  - Required: cnt holds at 0; done at cycle 5; stall held through cycle 4.
